// File: rtl/arb_pkg.sv
// Shared constants for the data_memory port arbiter: port indices,
// default starvation bound and statistics counter width.
package arb_pkg;
    localparam int ARB_PORT_CPU     = 0;
    localparam int ARB_PORT_LDR     = 1;
    localparam int ARB_HOLD_MAX_DEF = 4;
    localparam int ARB_STAT_W       = 16;
    localparam int ARB_HOLD_W       = 4;

    typedef logic [ARB_HOLD_W-1:0] hold_cnt_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones and never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clock,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between CPU (port 0) and loader (port 1),
// with lock/starvation bound and tagged read return. ARB_STATS_EN adds grant/wait counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = ARB_HOLD_MAX_DEF,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
`ifdef ARB_STATS_EN
    output logic [ARB_STAT_W-1:0] stat_gnt0,
    output logic [ARB_STAT_W-1:0] stat_gnt1,
    output logic [ARB_STAT_W-1:0] stat_wait,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam hold_cnt_t HOLD_LIM = hold_cnt_t'(HOLD_MAX);

    logic        r_last_owner;
    hold_cnt_t   r_hold_cnt;
    logic [1:0]  r_rd_pend;
    logic [ADDR_W-1:0] r_mem_addr;

    logic w_any, w_keep, w_gsel, w_other_req;

    // Owner keeps a contended grant only while it locks and is under the bound.
    assign w_keep = (r_last_owner ? lock1 : lock0) && (r_hold_cnt < HOLD_LIM);

    always_comb begin
        w_gsel = req1;
        if (req0 && req1)
            w_gsel = w_keep ? r_last_owner : ~r_last_owner;
    end

    assign w_any       = (req0 | req1) & ~reset;
    assign w_other_req = w_gsel ? req0 : req1;

    assign gnt0      = w_any & (w_gsel == 1'(ARB_PORT_CPU));
    assign gnt1      = w_any & (w_gsel == 1'(ARB_PORT_LDR));
    assign mem_write = w_any & (w_gsel ? we1 : we0);
    assign mem_wdata = w_any ? (w_gsel ? wdata1 : wdata0) : '0;

    always_comb begin
        mem_addr = r_mem_addr;
        if (reset)
            mem_addr = '0;
        else if (w_any)
            mem_addr = w_gsel ? addr1 : addr0;
    end

    assign rvalid0 = r_rd_pend[0] & ~reset;
    assign rvalid1 = r_rd_pend[1] & ~reset;
    assign rdata   = reset ? '0 : mem_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_owner <= 1'(ARB_PORT_LDR);
            r_hold_cnt   <= '0;
            r_rd_pend    <= '0;
            r_mem_addr   <= '0;
        end else begin
            r_rd_pend <= {gnt1 & ~we1, gnt0 & ~we0};
            if (w_any) begin
                r_last_owner <= w_gsel;
                r_mem_addr   <= mem_addr;
                if (!w_other_req)
                    r_hold_cnt <= '0;
                else if (w_gsel != r_last_owner)
                    r_hold_cnt <= hold_cnt_t'(1);
                else if (r_hold_cnt < HOLD_LIM)
                    r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic w_wait;
    assign w_wait = (req0 & ~gnt0) | (req1 & ~gnt1);

    sat_counter #(.W(ARB_STAT_W)) u_cnt_gnt0 (
        .i_clock(clock), .i_clr(reset), .i_inc(gnt0),   .o_cnt(stat_gnt0));
    sat_counter #(.W(ARB_STAT_W)) u_cnt_gnt1 (
        .i_clock(clock), .i_clr(reset), .i_inc(gnt1),   .o_cnt(stat_gnt1));
    sat_counter #(.W(ARB_STAT_W)) u_cnt_wait (
        .i_clock(clock), .i_clr(reset), .i_inc(w_wait), .o_cnt(stat_wait));
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle RAM.
module tb_mem_port_arbiter;
    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_write;
`ifdef ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_wait;
    logic [15:0] wait_snap;
`endif

    int npass = 0;
    int ntot  = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.HOLD_MAX(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write),
`ifdef ARB_STATS_EN
        .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_wait(stat_wait),
`endif
        .mem_rdata(mem_rdata)
    );

    // RAM: contents preset to addr ^ 0x5A, write-first, data one cycle after address.
    logic [7:0] ram [256];
    logic       ram_loaded = 1'b0;
    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int k = 0; k < 256; k++) ram[k] <= 8'(k) ^ 8'h5A;
            ram_loaded <= 1'b1;
            mem_rdata  <= 8'h00;
        end else begin
            if (mem_write) ram[mem_addr] <= mem_wdata;
            mem_rdata <= mem_write ? mem_wdata : ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            npass++;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    endtask

    initial begin
        reset = 1; idle();
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        req0 = 1; req1 = 1;

        // reset held 2 cycles with both requesting: every output stays 0
        cyc(); cyc(); #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 0);
        chk("rst_rdata", rdata, 0);

        // tie after reset: port 0 first
        cyc(); reset = 0; addr0 = 8'h10; addr1 = 8'h20; #1;
        chk("tie_c1_gnt", {gnt1, gnt0}, 2'b01);
        chk("tie_c1_addr", mem_addr, 8'h10);
        cyc(); req0 = 0; #1;
        chk("tie_c2_gnt", {gnt1, gnt0}, 2'b10);
        chk("tie_c2_addr", mem_addr, 8'h20);
        chk("tie_c2_rvalid", {rvalid1, rvalid0}, 2'b01);
        chk("tie_c2_rdata", rdata, 8'h4A);
        cyc(); req1 = 0; #1;
        chk("tie_c3_gnt", {gnt1, gnt0}, 2'b00);
        chk("tie_c3_rvalid", {rvalid1, rvalid0}, 2'b10);
        chk("tie_c3_rdata", rdata, 8'h7A);
        chk("idle_addr_hold", mem_addr, 8'h20);
        chk("idle_write", mem_write, 0);

        // contention without lock: strict alternation starting at port 0
`ifdef ARB_STATS_EN
        wait_snap = stat_wait;
`endif
        for (int i = 0; i < 6; i++) begin
            cyc(); req0 = 1; req1 = 1; addr0 = 8'(8'h40 + i); addr1 = 8'(8'h80 + i); #1;
            chk($sformatf("rr_gnt%0d", i), {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0)
                chk($sformatf("rr_rvalid%0d", i), {rvalid1, rvalid0},
                    (i % 2 == 1) ? 2'b01 : 2'b10);
        end
        cyc(); idle(); #1;
        chk("rr_last_rvalid", {rvalid1, rvalid0}, 2'b10);
        chk("rr_last_rdata", rdata, 8'h85 ^ 8'h5A);
`ifdef ARB_STATS_EN
        chk("stat_wait_rr", 32'(stat_wait - wait_snap), 6);
`endif

        // lock0 with both requesting: 4 grants to port 0, then port 1, then port 0
        for (int i = 0; i < 6; i++) begin
            cyc(); req0 = 1; req1 = 1; lock0 = 1; #1;
            chk($sformatf("lock_gnt%0d", i), {gnt1, gnt0}, (i == 4) ? 2'b10 : 2'b01);
        end
        cyc(); idle(); #1;

        // write by port 1, then read of the same address by port 0
        req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 8'hA5; #1;
        chk("wr_gnt", {gnt1, gnt0}, 2'b10);
        chk("wr_strobe", mem_write, 1);
        chk("wr_addr", mem_addr, 8'h30);
        chk("wr_data", mem_wdata, 8'hA5);
        cyc(); idle(); req0 = 1; addr0 = 8'h30; #1;
        chk("rd_gnt", {gnt1, gnt0}, 2'b01);
        chk("rd_strobe", mem_write, 0);
        chk("wr_no_rvalid", {rvalid1, rvalid0}, 2'b00);
        cyc(); idle(); #1;
        chk("raw_rvalid", {rvalid1, rvalid0}, 2'b01);
        chk("raw_rdata", rdata, 8'hA5);

        // reset while port 1's read is in flight
        req1 = 1; addr1 = 8'h20; #1;
        chk("mid_gnt1", {gnt1, gnt0}, 2'b10);
        cyc(); reset = 1; req0 = 1; req1 = 1; addr0 = 8'h11; #1;
        chk("mid_rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        chk("mid_rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_addr", mem_addr, 0);
        cyc(); reset = 0; #1;
        chk("post_rst_gnt", {gnt1, gnt0}, 2'b01);
        chk("post_rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        cyc(); req0 = 0; #1;
        chk("post_rst_gnt2", {gnt1, gnt0}, 2'b10);
        chk("post_rst_rvalid2", {rvalid1, rvalid0}, 2'b01);
        chk("post_rst_rdata", rdata, 8'h11 ^ 8'h5A);
        cyc(); idle(); #1;

`ifdef ARB_STATS_EN
        // drive stat_gnt0 to 0xFFFE, then 3 more grants saturate it
        cyc(); reset = 1; #1;
        chk("stat_clr", stat_gnt0, 0);
        cyc(); reset = 0; req0 = 1; addr0 = 8'h00;
        repeat (16'hFFFE) @(posedge clock);
        #1;
        chk("stat_fffe", stat_gnt0, 16'hFFFE);
        repeat (3) @(posedge clock);
        #1;
        chk("stat_sat", stat_gnt0, 16'hFFFF);
        cyc(); idle(); #1;
        chk("stat_hold", stat_gnt0, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single `data_memory` port between the CPU core (port 0) and a program-loader/debug master (port 1). It sits between the requesters and the RAM, and drives the RAM address, write-data and write-strobe each cycle. Arbitration is round-robin, with an optional per-requester lock and a starvation bound. Read data is steered back to the requester that issued the read.

## Interface
- `HOLD_MAX`, 4: maximum consecutive grants to one port while the other port is requesting (range 1–15).
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: access request; held until granted.
- `we0`, `we1` in 1: 1 = write, 0 = read; valid with `req`.
- `lock0`, `lock1` in 1: request to keep ownership on the next grant.
- `addr0`, `addr1` in `ADDR_W`: access address.
- `wdata0`, `wdata1` in `DATA_W`: write data.
- `gnt0`, `gnt1` out 1: access performed this cycle.
- `rvalid0`, `rvalid1` out 1: `rdata` valid for this port.
- `rdata` out `DATA_W`: read data, shared by both ports.
- `mem_addr` out `ADDR_W`: RAM address.
- `mem_wdata` out `DATA_W`: RAM write data.
- `mem_write` out 1: RAM write strobe.
- `mem_rdata` in `DATA_W`: RAM read data; valid one cycle after the address.

## Operation
- **Grant decision.** Combinational from `req0`/`req1` plus registered state.
  - `last_owner`: 1 bit.
  - `hold_cnt`: 4 bits.
  - `rd_pend`: 2 bits, one-hot read-return tag.
- **Single request.** The requesting port is granted.
- **Both requesting.** The port ≠ `last_owner` wins, unless both of these hold:
  - the `last_owner` port asserts its `lock`, and
  - `hold_cnt < HOLD_MAX`.
  - In that case the `last_owner` port keeps the grant.
- **Grant cycle.**
  - Exactly one of `gnt0`/`gnt1` is high.
  - `mem_addr`, `mem_wdata` and `mem_write` are taken from the granted port.
  - `last_owner` ← granted port.
- **hold_cnt update.**
  - Increments on a grant to the same port while the other port was requesting.
  - Resets to 1 on an ownership change.
  - Resets to 0 when the other port was not requesting.
  - Saturates at `HOLD_MAX`.
- **Idle cycle** (no request):
  - `mem_write` = 0.
  - `mem_addr` holds its last value.
  - `hold_cnt` ← 0; `last_owner` unchanged.
- **Read return.**
  - A granted read sets the matching `rd_pend` bit for the next cycle.
  - `rvalid0`/`rvalid1` = `rd_pend` bits; `rdata` = `mem_rdata` pass-through.
  - Granted writes set no `rd_pend` bit.
- **Back-to-back reads.** Allowed, from the same port or alternating ports. Each grant's `rvalid` follows it by exactly one cycle, in grant order.
- **Read/write hazard.** A read granted the cycle after a write to the same address returns the new data (RAM write-first ordering is defined by grant order).
- **Reset** (any cycle, including mid-access):
  - All outputs are 0.
  - `last_owner` = 1, so port 0 wins the first tie.
  - `hold_cnt` = 0; `rd_pend` = 0.
  - Any read in flight is dropped and its `rvalid` is never issued.

## Timing
- Grant latency: 0 cycles; `gnt` is in the same cycle as `req` when uncontended.
- Read data latency: 1 cycle after `gnt`.
- Under contention without lock: strict alternation, so worst-case wait is 1 cycle.
- With lock: worst-case wait is `HOLD_MAX` cycles.
- A requester holding `req` high after its `gnt` issues a new access. It must change `addr`/`we`/`wdata` in the cycle after `gnt` if a different access is intended.
- The combinational path is `req` → `gnt` → `mem_*`. No combinational path from `mem_rdata` to `gnt`.

## Configuration
- `ARB_STATS_EN` defined adds three 16-bit saturating counters and ports:
  - `stat_gnt0` out 16: grants to port 0.
  - `stat_gnt1` out 16: grants to port 1.
  - `stat_wait` out 16: cycles in which a requesting port was not granted.
  - All three clear on `reset`, saturate at 0xFFFF and never wrap.
- `ARB_STATS_EN` undefined: the counters and ports are absent; arbitration behaviour is identical.

## Structure
- Shared package `arb_pkg`:
  - port index constants `ARB_PORT_CPU` = 0 and `ARB_PORT_LDR` = 1;
  - `HOLD_MAX` default;
  - stats counter width constant (16).
- Sub-module `sat_counter` (parameterised width, `inc`/`clr`): instantiated three times under `ARB_STATS_EN`.

## Test plan
- **Reset tie-break:** `reset` for 2 cycles, then `req0`=`req1`=1 reads at 0x10/0x20 → `gnt0` in cycle 1, `gnt1` in cycle 2; `rvalid0` in cycle 2, `rvalid1` in cycle 3, with `rdata` = RAM contents at each address.
- **Contention, no lock:** both ports request for 6 cycles → `gnt` pattern 0,1,0,1,0,1; `stat_wait` = 6 with `ARB_STATS_EN`.
- **Lock starvation bound:** `lock0`=1 with both requesting, `HOLD_MAX`=4 → port 0 granted 4 consecutive cycles, then `gnt1`, then port 0 again.
- **Write-then-read:** port 1 writes 0xA5 to 0x30; the next cycle port 0 reads 0x30 → `rvalid0` with `rdata` = 0xA5; `rvalid1` never asserted.
- **Reset mid-read:** read granted to port 1, `reset` asserted the next cycle → `rvalid1` = 0 and all outputs 0 that cycle; the first grant after reset goes to port 0 on a tie.
- **Counter saturation** (`ARB_STATS_EN`): force `stat_gnt0` to 0xFFFE, issue 3 port-0 grants → reads 0xFFFF and holds.
